// File: rtl/ir_sched_pkg.sv
// Shared types and constants for the IR car scheduler: FSM states, register
// offsets relative to BASE_ADDR, default addresses and the one-hot helper.
package ir_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LOAD,
        ST_DWELL,
        ST_NEUTRAL,
        ST_GUARD
    } state_e;

    localparam logic [7:0] OFS_CMD0 = 8'd0;
    localparam logic [7:0] OFS_CMD1 = 8'd1;
    localparam logic [7:0] OFS_CMD2 = 8'd2;
    localparam logic [7:0] OFS_CMD3 = 8'd3;
    localparam logic [7:0] OFS_MASK = 8'd4;

    localparam logic [7:0] BASE_ADDR_DEF = 8'h94;
    localparam logic [7:0] TX_ADDR_DEF   = 8'h90;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ir_sched_if.sv
// Processor-bus write port in, transmitter write port out. The scheduler sits
// on the slave side; the bus decode / transmitter model sits on the master side.
interface ir_sched_if;
    logic       BUS_WE;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       TX_WE;
    logic [7:0] TX_ADDR;
    logic [7:0] TX_DATA;

    modport master (
        output BUS_WE, BUS_ADDR, BUS_DATA,
        input  TX_WE, TX_ADDR, TX_DATA
    );

    modport slave (
        input  BUS_WE, BUS_ADDR, BUS_DATA,
        output TX_WE, TX_ADDR, TX_DATA
    );
endinterface

// File: rtl/ir_rr_pick.sv
// Combinational round-robin picker: first enabled car strictly after `last`,
// wrapping 0..3; `last` itself is only chosen when it is the sole enabled car.
module ir_rr_pick (
    input  logic [3:0] mask,
    input  logic [1:0] last,
    output logic [1:0] next,
    output logic       valid
);
    always_comb begin
        next  = last;
        valid = |mask;
        // Walk from farthest to nearest so the nearest enabled car wins.
        for (int i = 4; i >= 1; i--) begin
            if (mask[last + 2'(i)]) begin
                next = last + 2'(i);
            end
        end
    end
endmodule

// File: rtl/ir_car_scheduler.sv
// Time-slices the IR transmitter between four cars in round-robin order.
// Optional IR_SCHED_WATCHDOG_EN zeroes a car's command after TIMEOUT_SLOTS unrefreshed slots.
module ir_car_scheduler
    import ir_sched_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR     = BASE_ADDR_DEF,
    parameter logic [7:0]  TX_ADDR       = TX_ADDR_DEF,
    parameter int unsigned SLOT_CYCLES   = 10_000_000,
    parameter int unsigned GUARD_CYCLES  = 50_000,
    parameter int unsigned TIMEOUT_SLOTS = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    ir_sched_if.slave        bus,
    output logic [1:0]       ACTIVE_CAR,
    output logic             BUSY
);
    // Wide enough to hold SLOT_CYCLES itself, including power-of-two values.
    localparam int DW = $clog2(SLOT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    if (SLOT_CYCLES < 2 || GUARD_CYCLES < 1 || TIMEOUT_SLOTS > 15) begin : g_bad_params
        $error("ir_car_scheduler: illegal SLOT/GUARD/TIMEOUT parameters");
    end

    state_e          state_q, state_d;
    logic [3:0][3:0] cmd_q, cmd_d, cmd_eff;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      cmd_wr_q, cmd_wr_d;
    logic [1:0]      active_q, active_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            tx_we_q, tx_we_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;

    logic            load_go;
    logic [1:0]      load_car;
    logic [1:0]      pick_next;
    logic            pick_valid;
    logic [7:0]      wr_off;

    ir_rr_pick u_pick (
        .mask  (mask_q),
        .last  (active_q),
        .next  (pick_next),
        .valid (pick_valid)
    );

    assign wr_off = bus.BUS_ADDR - BASE_ADDR;

`ifdef IR_SCHED_WATCHDOG_EN
    localparam logic [3:0] WD_LIMIT = 4'(TIMEOUT_SLOTS);
    logic [3:0][3:0] wd_q, wd_d;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cmd_eff[k] = (wd_q[k] >= WD_LIMIT) ? 4'h0 : cmd_q[k];
        end
    end
`else
    assign cmd_eff = cmd_q;
`endif

    // Register file: watchdog forcing first, so a same-cycle bus write wins.
    always_comb begin
        mask_d   = mask_q;
        cmd_d    = cmd_q;
        cmd_wr_d = '0;
`ifdef IR_SCHED_WATCHDOG_EN
        wd_d = wd_q;
        if (load_go) begin
            if (wd_q[load_car] >= WD_LIMIT) cmd_d[load_car] = 4'h0;
            if (wd_q[load_car] != 4'hF)     wd_d[load_car]  = wd_q[load_car] + 4'd1;
        end
`endif
        if (bus.BUS_WE) begin
            if (wr_off == OFS_MASK) begin
                mask_d = bus.BUS_DATA[3:0];
            end else if (wr_off <= OFS_CMD3) begin
                cmd_d[wr_off[1:0]]    = bus.BUS_DATA[3:0];
                cmd_wr_d[wr_off[1:0]] = 1'b1;
`ifdef IR_SCHED_WATCHDOG_EN
                wd_d[wr_off[1:0]] = 4'h0;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        dwell_d   = dwell_q;
        guard_d   = guard_q;
        tx_we_d   = 1'b0;
        tx_data_d = tx_data_q;
        load_go   = 1'b0;
        load_car  = active_q;
        unique case (state_q)
            ST_IDLE: if (|mask_q) state_d = ST_SELECT;
            ST_SELECT: begin
                if (pick_valid) begin
                    state_d  = ST_LOAD;
                    active_d = pick_next;
                    load_go  = 1'b1;
                    load_car = pick_next;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_DWELL;
                dwell_d = DW'(SLOT_CYCLES);
            end
            ST_DWELL: begin
                dwell_d = dwell_q - 1'b1;
                if (!mask_q[active_q] || (dwell_q == DW'(1) && mask_q != onehot4(active_q))) begin
                    state_d   = ST_NEUTRAL;
                    tx_we_d   = 1'b1;
                    tx_data_d = 8'h00;
                end else if (dwell_q == DW'(1)) begin
                    state_d = ST_LOAD;
                    load_go = 1'b1;
                end else if (cmd_wr_q[active_q]) begin
                    tx_we_d   = 1'b1;
                    tx_data_d = {onehot4(active_q), cmd_eff[active_q]};
                end
            end
            ST_NEUTRAL: begin
                state_d = ST_GUARD;
                guard_d = GW'(GUARD_CYCLES);
            end
            ST_GUARD: begin
                guard_d = guard_q - 1'b1;
                if (guard_q == GW'(1)) state_d = ST_SELECT;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_go) begin
            tx_we_d   = 1'b1;
            tx_data_d = {onehot4(load_car), cmd_eff[load_car]};
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            mask_q    <= '0;
            cmd_wr_q  <= '0;
            active_q  <= 2'd3;
            dwell_q   <= '0;
            guard_q   <= '0;
            tx_we_q   <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
`ifdef IR_SCHED_WATCHDOG_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            mask_q    <= mask_d;
            cmd_wr_q  <= cmd_wr_d;
            active_q  <= active_d;
            dwell_q   <= dwell_d;
            guard_q   <= guard_d;
            tx_we_q   <= tx_we_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
`ifdef IR_SCHED_WATCHDOG_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign bus.TX_WE   = tx_we_q;
    assign bus.TX_DATA = tx_data_q;
    assign bus.TX_ADDR = TX_ADDR;
    assign ACTIVE_CAR  = active_q;
    assign BUSY        = busy_q;
endmodule

// File: tb/tb_ir_car_scheduler.sv
// Directed bench for ir_car_scheduler (SLOT=20, GUARD=4, TIMEOUT=2); every
// transmitter write is logged with its cycle and compared to hand-derived slots.
module tb_ir_car_scheduler;
    import ir_sched_pkg::*;

    localparam logic [7:0] BASE = 8'h94;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] ACTIVE_CAR;
    logic       BUSY;

    ir_sched_if bus ();

    ir_car_scheduler #(
        .SLOT_CYCLES   (20),
        .GUARD_CYCLES  (4),
        .TIMEOUT_SLOTS (2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus),
        .ACTIVE_CAR (ACTIVE_CAR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    always @(posedge CLK) begin
        #1;
        if (bus.TX_WE === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(bus.TX_DATA);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int wr_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input int exp_cyc, input logic [7:0] exp_dat);
        if (idx < ev_cyc.size()) begin
            chk({tag, "_cyc"}, ev_cyc[idx], exp_cyc);
            chk({tag, "_dat"}, ev_dat[idx], exp_dat);
        end else begin
            chk({tag, "_missing"}, ev_cyc.size(), idx + 1);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the strobe dropped.
    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus.BUS_WE   = 1'b1;
        bus.BUS_ADDR = a;
        bus.BUS_DATA = d;
        wr_cyc       = cyc;
        @(negedge CLK);
        bus.BUS_WE   = 1'b0;
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        bus.BUS_WE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        ev_cyc.delete();
        ev_dat.delete();
    endtask

    initial begin
        int t;
        logic [7:0] exp3;
        RESET        = 1'b1;
        bus.BUS_WE   = 1'b0;
        bus.BUS_ADDR = 8'h00;
        bus.BUS_DATA = 8'h00;
        @(negedge CLK);

        // Reset state
        do_reset();
        chk("rst_tx_we", bus.TX_WE, 1'b0);
        chk("rst_tx_data", bus.TX_DATA, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_active", ACTIVE_CAR, 2'd3);
        chk("tx_addr", bus.TX_ADDR, 8'h90);

        // 1: single car, back-to-back slots with no neutral
        do_reset();
        bus_wr(BASE + OFS_CMD0, 8'h05);
        bus_wr(BASE + OFS_MASK, 8'h01);
        t = wr_cyc + 3;
        repeat (45) @(negedge CLK);
`ifdef IR_SCHED_WATCHDOG_EN
        exp3 = 8'h10;
`else
        exp3 = 8'h15;
`endif
        chk_ev("t1_l0", 0, t, 8'h15);
        chk_ev("t1_l1", 1, t + 21, 8'h15);
        chk_ev("t1_l2", 2, t + 42, exp3);
        chk("t1_count", ev_cyc.size(), 3);
        chk("t1_active", ACTIVE_CAR, 2'd0);
        chk("t1_busy", BUSY, 1'b1);

        // 2: two cars alternate with neutral + guard; stray addresses ignored
        do_reset();
        bus_wr(8'h93, 8'h0F);
        bus_wr(8'h99, 8'h0F);
        bus_wr(BASE + OFS_CMD0, 8'h03);
        bus_wr(BASE + OFS_CMD2, 8'h0A);
        bus_wr(BASE + OFS_MASK, 8'h05);
        t = wr_cyc + 3;
        repeat (57) @(negedge CLK);
        chk_ev("t2_c0", 0, t, 8'h13);
        chk_ev("t2_n0", 1, t + 21, 8'h00);
        chk_ev("t2_c2", 2, t + 27, 8'h4A);
        chk_ev("t2_n1", 3, t + 48, 8'h00);
        chk_ev("t2_c0b", 4, t + 54, 8'h13);
        chk("t2_count", ev_cyc.size(), 5);

        // 3: command rewrite during car 2's dwell
        do_reset();
        bus_wr(BASE + OFS_CMD0, 8'h03);
        bus_wr(BASE + OFS_CMD2, 8'h0A);
        bus_wr(BASE + OFS_MASK, 8'h05);
        t = wr_cyc + 3;
        repeat (34) @(negedge CLK);
        bus_wr(BASE + OFS_CMD2, 8'h01);
        repeat (16) @(negedge CLK);
        chk_ev("t3_c2", 2, t + 27, 8'h4A);
        chk_ev("t3_upd", 3, t + 34, 8'h41);
        chk_ev("t3_neu", 4, t + 48, 8'h00);
        chk("t3_count", ev_cyc.size(), 5);
        chk("t3_active", ACTIVE_CAR, 2'd2);

        // 4: mask cleared mid-dwell
        do_reset();
        bus_wr(BASE + OFS_CMD0, 8'h05);
        bus_wr(BASE + OFS_MASK, 8'h01);
        t = wr_cyc + 3;
        repeat (9) @(negedge CLK);
        bus_wr(BASE + OFS_MASK, 8'h00);
        repeat (5) @(negedge CLK);
        chk("t4_busy_guard", BUSY, 1'b1);
        repeat (2) @(negedge CLK);
        chk("t4_busy_idle", BUSY, 1'b0);
        repeat (30) @(negedge CLK);
        chk_ev("t4_load", 0, t, 8'h15);
        chk_ev("t4_neu", 1, t + 9, 8'h00);
        chk("t4_count", ev_cyc.size(), 2);
        chk("t4_busy_end", BUSY, 1'b0);

        // 5: reset during car 1's dwell, then re-enable
        do_reset();
        bus_wr(BASE + OFS_CMD0, 8'h05);
        bus_wr(BASE + OFS_CMD1, 8'h07);
        bus_wr(BASE + OFS_MASK, 8'h03);
        t = wr_cyc + 3;
        repeat (37) @(negedge CLK);
        chk_ev("t5_c1", 2, t + 27, 8'h27);
        chk("t5_active_pre", ACTIVE_CAR, 2'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("t5_tx_we", bus.TX_WE, 1'b0);
        chk("t5_tx_data", bus.TX_DATA, 8'h00);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_active", ACTIVE_CAR, 2'd3);
        RESET = 1'b0;
        ev_cyc.delete();
        ev_dat.delete();
        bus_wr(BASE + OFS_CMD2, 8'h09);
        bus_wr(BASE + OFS_MASK, 8'h05);
        t = wr_cyc + 3;
        repeat (3) @(negedge CLK);
        chk_ev("t5_first", 0, t, 8'h10);
        chk("t5_active_post", ACTIVE_CAR, 2'd0);

`ifdef IR_SCHED_WATCHDOG_EN
        // 6: watchdog zeroes a stale command, a rewrite restores it
        do_reset();
        bus_wr(BASE + OFS_CMD0, 8'h05);
        bus_wr(BASE + OFS_MASK, 8'h01);
        t = wr_cyc + 3;
        repeat (49) @(negedge CLK);
        bus_wr(BASE + OFS_CMD0, 8'h05);
        repeat (16) @(negedge CLK);
        chk_ev("t6_l1", 1, t + 21, 8'h15);
        chk_ev("t6_l2", 2, t + 42, 8'h10);
        chk_ev("t6_upd", 3, t + 49, 8'h15);
        chk_ev("t6_l3", 4, t + 63, 8'h15);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
